// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // Canonical NOP (addi x0, x0, 0) shown to decode whenever no real word is presented.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One fetched word together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant + read-valid bus.
interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

  // Pointer and occupancy next-state; pointers wrap at DEPTH-1 so any depth works.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC owner, credit-limited imem requester, output queue to decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  fetch_stage_if.master imem,
  output logic [31:0]   PC_Out,
  output logic [31:0]   instruction,
  output logic          fetch_valid_o
);

  localparam int unsigned   CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   pc_q, pc_d, last_pc_q, last_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] occ, infl_cnt;
  logic [CW:0]   credit_used;
  logic          fire, keep, oq_pop, oq_empty, infl_empty, unused_infl;
  fetch_entry_t  head, infl_head, oq_wdata, infl_wdata;

  // Outstanding responses (including ones to be dropped) plus buffered words must fit the queue.
  assign credit_used      = {1'b0, outstanding_q} + {1'b0, occ};
  assign imem.imem_req_o  = !rst && !redirect_i && (credit_used < DEPTH_C);
  assign imem.imem_addr_o = pc_q;
  assign fire             = imem.imem_req_o && imem.imem_gnt_i;
  assign keep             = imem.imem_rvalid_i && (drop_cnt_q == '0) && !redirect_i;

  assign infl_wdata = '{pc: pc_q, instr: '0};
  assign oq_wdata   = '{pc: infl_head.pc, instr: imem.imem_rdata_i};
  assign oq_pop     = fetch_valid_o && !stall_i;
  assign unused_infl = ^{infl_cnt, infl_empty, infl_head.instr};

  // Addresses of granted requests, matched in order against returning data.
  fetch_queue #(.DEPTH(BUF_DEPTH)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .pop   (imem.imem_rvalid_i),
    .flush (1'b0),
    .wdata (infl_wdata),
    .rdata (infl_head),
    .count (infl_cnt),
    .empty (infl_empty)
  );

  fetch_queue #(.DEPTH(BUF_DEPTH)) u_outq (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .pop   (oq_pop),
    .flush (redirect_i),
    .wdata (oq_wdata),
    .rdata (head),
    .count (occ),
    .empty (oq_empty)
  );

  // PC, outstanding and drop-count next-state; redirect overrides the normal PC advance.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(fire) - CW'(imem.imem_rvalid_i);
    drop_cnt_d    = drop_cnt_q;
    if (redirect_i) begin
      pc_d       = redirect_pc_i & ~32'h3;
      drop_cnt_d = outstanding_q - CW'(imem.imem_rvalid_i);
    end else begin
      if (fire) pc_d = pc_q + 32'd4;
      if (imem.imem_rvalid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Decode-facing outputs straight from the queue head; PC_Out holds its last value when empty.
  always_comb begin
    fetch_valid_o = !oq_empty;
    instruction   = fetch_valid_o ? head.instr : NOP_INSTR;
    PC_Out        = fetch_valid_o ? head.pc : last_pc_q;
    last_pc_d     = PC_Out;
  end

  // Stage state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      last_pc_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      last_pc_q     <= last_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus hand sequences.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_b;
  logic        stall_a, redir_a, tie0;
  logic [31:0] rpc_a, tie0w;
  logic [31:0] pc_a, ins_a, pc_b, ins_b, pc_c, ins_c;
  logic        val_a, val_b, val_c;
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_stage_if ifa ();
  fetch_stage_if ifb ();
  fetch_stage_if ifc ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .stall_i(stall_a), .redirect_i(redir_a), .redirect_pc_i(rpc_a),
    .imem(ifa), .PC_Out(pc_a), .instruction(ins_a), .fetch_valid_o(val_a));

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .stall_i(tie0), .redirect_i(tie0), .redirect_pc_i(tie0w),
    .imem(ifb), .PC_Out(pc_b), .instruction(ins_b), .fetch_valid_o(val_b));

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(3)) dut_c (
    .clk(clk), .rst(rst_b), .stall_i(tie0), .redirect_i(tie0), .redirect_pc_i(tie0w),
    .imem(ifc), .PC_Out(pc_c), .instruction(ins_c), .fetch_valid_o(val_c));

  typedef struct {
    logic        stall, redir;
    logic [31:0] rpc;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc, e_ins;
  } vec_t;

  vec_t tv [26];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic g, input logic v, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei);
    vec_t t;
    t.stall = s;  t.redir = r;  t.rpc = rpc;  t.gnt = g;  t.rv = v;  t.rdata = rd;
    t.e_req = er; t.e_addr = ea; t.e_val = ev; t.e_pc = ep; t.e_ins = ei;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        pend_b, pend_c;
    logic [31:0] pdat_b, pdat_c;

    //          stall redir rpc       gnt   rv    rdata        req   addr       val   pc_out     instr
    tv[0]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b1, 32'h0,    1'b0, 32'h0,    NOP_INSTR);
    tv[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, mw(32'h0),   1'b1, 32'h4,    1'b0, 32'h0,    NOP_INSTR);
    tv[2]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, mw(32'h4),   1'b0, 32'h8,    1'b1, 32'h0,    mw(32'h0));
    tv[3]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b0, 32'h8,    1'b1, 32'h0,    mw(32'h0));
    tv[4]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b0, 32'h8,    1'b1, 32'h0,    mw(32'h0));
    tv[5]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b0, 32'h8,    1'b1, 32'h0,    mw(32'h0));
    tv[6]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b1, 32'h8,    1'b1, 32'h4,    mw(32'h4));
    tv[7]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, mw(32'h8),   1'b1, 32'hC,    1'b0, 32'h4,    NOP_INSTR);
    tv[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b1, 32'hC,    1'b1, 32'h8,    mw(32'h8));
    tv[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b1, 32'h10,   1'b0, 32'h8,    NOP_INSTR);
    tv[10] = mk(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,       1'b0, 32'h14,   1'b0, 32'h8,    NOP_INSTR);
    tv[11] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, mw(32'hC),   1'b0, 32'h100,  1'b0, 32'h8,    NOP_INSTR);
    tv[12] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, mw(32'h10),  1'b1, 32'h100,  1'b0, 32'h8,    NOP_INSTR);
    tv[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, mw(32'h100), 1'b1, 32'h104,  1'b0, 32'h8,    NOP_INSTR);
    tv[14] = mk(1'b1, 1'b1, 32'h102, 1'b1, 1'b1, mw(32'h104), 1'b0, 32'h108,  1'b1, 32'h100,  mw(32'h100));
    tv[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b1, 32'h100,  1'b0, 32'h100,  NOP_INSTR);
    tv[16] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, mw(32'h100), 1'b1, 32'h104,  1'b0, 32'h100,  NOP_INSTR);
    tv[17] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,       1'b1, 32'h104,  1'b1, 32'h100,  mw(32'h100));
    tv[18] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,       1'b1, 32'h104,  1'b0, 32'h100,  NOP_INSTR);
    tv[19] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b1, 32'h104,  1'b0, 32'h100,  NOP_INSTR);
    tv[20] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,       1'b1, 32'h108,  1'b0, 32'h100,  NOP_INSTR);
    tv[21] = mk(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, mw(32'h104), 1'b0, 32'h10C,  1'b0, 32'h100,  NOP_INSTR);
    tv[22] = mk(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0,       1'b0, 32'h200,  1'b0, 32'h100,  NOP_INSTR);
    tv[23] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, mw(32'h108), 1'b1, 32'h300,  1'b0, 32'h100,  NOP_INSTR);
    tv[24] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, mw(32'h300), 1'b1, 32'h304,  1'b0, 32'h100,  NOP_INSTR);
    tv[25] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,       1'b1, 32'h304,  1'b1, 32'h300,  mw(32'h300));

    rst = 1'b1;  rst_b = 1'b1;  tie0 = 1'b0;  tie0w = '0;
    stall_a = 1'b0;  redir_a = 1'b0;  rpc_a = '0;
    ifa.imem_gnt_i = 1'b0;  ifa.imem_rvalid_i = 1'b0;  ifa.imem_rdata_i = '0;
    ifb.imem_gnt_i = 1'b1;  ifb.imem_rvalid_i = 1'b0;  ifb.imem_rdata_i = '0;
    ifc.imem_gnt_i = 1'b1;  ifc.imem_rvalid_i = 1'b0;  ifc.imem_rdata_i = '0;
    pend_b = 1'b0;  pend_c = 1'b0;  pdat_b = '0;  pdat_c = '0;

    repeat (2) @(negedge clk);
    chk("reset req",   32'(ifa.imem_req_o), 32'h0);
    chk("reset valid", 32'(val_a),          32'h0);
    chk("reset instr", ins_a,               NOP_INSTR);
    chk("reset pc",    pc_a,                32'h0);
    rst = 1'b0;

    // Per-cycle vectors: streaming, stall, redirects with drops, redirect over stall
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      stall_a = tv[i].stall;  redir_a = tv[i].redir;  rpc_a = tv[i].rpc;
      ifa.imem_gnt_i = tv[i].gnt;  ifa.imem_rvalid_i = tv[i].rv;  ifa.imem_rdata_i = tv[i].rdata;
      #1;
      chk($sformatf("v%0d req", i),   32'(ifa.imem_req_o), 32'(tv[i].e_req));
      chk($sformatf("v%0d addr", i),  ifa.imem_addr_o,     tv[i].e_addr);
      chk($sformatf("v%0d valid", i), 32'(val_a),          32'(tv[i].e_val));
      chk($sformatf("v%0d pc", i),    pc_a,                tv[i].e_pc);
      chk($sformatf("v%0d instr", i), ins_a,               tv[i].e_ins);
    end

    // Asynchronous reset while a valid word is held under stall
    @(negedge clk);
    stall_a = 1'b0;  redir_a = 1'b0;  rpc_a = '0;
    ifa.imem_gnt_i = 1'b1;  ifa.imem_rvalid_i = 1'b0;  ifa.imem_rdata_i = '0;
    @(negedge clk);
    ifa.imem_gnt_i = 1'b0;  ifa.imem_rvalid_i = 1'b1;  ifa.imem_rdata_i = mw(32'h304);
    @(negedge clk);
    ifa.imem_rvalid_i = 1'b0;  stall_a = 1'b1;
    #1;
    chk("pre-rst valid", 32'(val_a), 32'h1);
    chk("pre-rst pc",    pc_a,       32'h304);
    #1 rst = 1'b1;
    #1;
    chk("mid-rst req",   32'(ifa.imem_req_o), 32'h0);
    chk("mid-rst valid", 32'(val_a),          32'h0);
    chk("mid-rst instr", ins_a,               NOP_INSTR);
    chk("mid-rst pc",    pc_a,                32'h0);
    @(negedge clk);
    rst = 1'b0;  stall_a = 1'b0;
    #1;
    chk("post-rst req",  32'(ifa.imem_req_o), 32'h1);
    chk("post-rst addr", ifa.imem_addr_o,     32'h0);

    // Always-granting memory with one-cycle read latency for the wrap and streaming instances
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ifb.imem_rvalid_i = pend_b;  ifb.imem_rdata_i = pdat_b;
      ifc.imem_rvalid_i = pend_c;  ifc.imem_rdata_i = pdat_c;
      if (c == 0) rst_b = 1'b0;
      #1;
      pend_b = ifb.imem_req_o && ifb.imem_gnt_i;  pdat_b = mw(ifb.imem_addr_o);
      pend_c = ifc.imem_req_o && ifc.imem_gnt_i;  pdat_c = mw(ifc.imem_addr_o);
      if (c == 0) chk("wrap addr0", ifb.imem_addr_o, 32'hFFFF_FFFC);
      if (c == 1) chk("wrap addr1", ifb.imem_addr_o, 32'h0000_0000);
      if (c == 2) begin
        chk("wrap valid", 32'(val_b), 32'h1);
        chk("wrap pc",    pc_b,       32'hFFFF_FFFC);
        chk("wrap instr", ins_b,      mw(32'hFFFF_FFFC));
      end
      if (c < 2) begin
        chk($sformatf("stream c%0d valid", c), 32'(val_c), 32'h0);
      end else begin
        chk($sformatf("stream c%0d valid", c), 32'(val_c), 32'h1);
        chk($sformatf("stream c%0d pc", c),    pc_c,       32'(4 * (c - 2)));
        chk($sformatf("stream c%0d instr", c), ins_c,      mw(32'(4 * (c - 2))));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
